// File: rtl/mem_addr_ctrl_pkg.sv
// Shared encodings for the PC/memory-address unit: PC source codes, address
// source, access sizes, FSM states and the data-alignment helper.
package mem_addr_ctrl_pkg;

  localparam int REG_LEN_DEF = 32;

  localparam logic [2:0] PC_ALU  = 3'd0;
  localparam logic [2:0] PC_P4   = 3'd1;
  localparam logic [2:0] PC_M4   = 3'd2;
  localparam logic [2:0] PC_OLD  = 3'd3;
  localparam logic [2:0] PC_TRAP = 3'd4;

  localparam logic MEM_PC  = 1'b0;
  localparam logic MEM_ALU = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Byte accesses (and the unused size code 3) never fault.
  function automatic logic data_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
    logic mis;
    mis = 1'b0;
    if (size == SZ_H) mis = addr_lo[0];
    else if (size == SZ_W) mis = |addr_lo;
    return mis;
  endfunction

endpackage

// File: rtl/mem_addr_ctrl_if.sv
// Memory-port bundle between the address unit (master) and main memory (slave).
interface mem_addr_ctrl_if import mem_addr_ctrl_pkg::*; #(
  parameter int REG_LEN = REG_LEN_DEF
);
  logic [REG_LEN-1:0] addr;
  logic               mem_req;
  logic               mem_ready;

  modport master (output addr, output mem_req, input mem_ready);
  modport slave  (input addr, input mem_req, output mem_ready);
endinterface

// File: rtl/mem_addr_ctrl_pc_next.sv
// Combinational next-PC selection with instruction-alignment check on jumps.
module pc_next import mem_addr_ctrl_pkg::*; #(
  parameter int                 REG_LEN  = REG_LEN_DEF,
  parameter logic [REG_LEN-1:0] TRAP_VEC = REG_LEN'(32'h0000_0100),
  parameter int unsigned        STEP     = 4,
  parameter int                 IALIGN   = 2
) (
  input  logic [REG_LEN-1:0] pc_i,
  input  logic [REG_LEN-1:0] alu_out_i,
  input  logic [2:0]         pc_sel_i,
  output logic [REG_LEN-1:0] pc_nxt_o,
  output logic [REG_LEN-1:0] epc_nxt_o,
  output logic               epc_we_o,
  output logic               mis_pc_o
);

  logic jump_mis;
  assign jump_mis = (alu_out_i[IALIGN-1:0] != '0);

  always_comb begin
    pc_nxt_o  = pc_i;
    epc_nxt_o = pc_i;
    epc_we_o  = 1'b0;
    mis_pc_o  = 1'b0;
    case (pc_sel_i)
      PC_ALU: begin
        if (jump_mis) begin
          // A bad jump target traps; the target itself is what gets recorded.
          pc_nxt_o  = TRAP_VEC;
          epc_nxt_o = alu_out_i;
          epc_we_o  = 1'b1;
          mis_pc_o  = 1'b1;
        end else begin
          pc_nxt_o = alu_out_i;
        end
      end
      PC_P4:   pc_nxt_o = pc_i + REG_LEN'(STEP);
      PC_M4:   pc_nxt_o = pc_i - REG_LEN'(STEP);
      PC_TRAP: begin
        pc_nxt_o = TRAP_VEC;
        epc_we_o = 1'b1;
      end
      default: pc_nxt_o = pc_i;
    endcase
  end

endmodule

// File: rtl/mem_addr_ctrl.sv
// Program counter, exception PC and memory-address FSM with request/ready
// handshake; the address is frozen while memory stalls.
module mem_addr_ctrl import mem_addr_ctrl_pkg::*; #(
  parameter int                 REG_LEN  = REG_LEN_DEF,
  parameter logic [REG_LEN-1:0] RESET_PC = '0,
  parameter logic [REG_LEN-1:0] TRAP_VEC = REG_LEN'(32'h0000_0100),
  parameter int unsigned        STEP     = 4,
  parameter int                 IALIGN   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         pc_sel,
  input  logic               pc_upd,
  input  logic               mem_sel,
  input  logic [1:0]         acc_size,
  input  logic               req_valid,
  input  logic [REG_LEN-1:0] alu_out,
  output logic [REG_LEN-1:0] pc,
  output logic [REG_LEN-1:0] epc,
  output logic               done,
  output logic               busy,
  output logic               mis_pc,
  output logic               mis_data,
  mem_addr_ctrl_if.master    mem
);

  state_e             state_q, state_d;
  logic [REG_LEN-1:0] pc_q, pc_d;
  logic [REG_LEN-1:0] epc_q, epc_d;
  logic [REG_LEN-1:0] addr_q, addr_d;
  logic               mem_req_q, mem_req_d;
  logic               done_q, done_d;
  logic               mis_pc_q, mis_pc_d;
  logic               mis_data_q, mis_data_d;

  logic [REG_LEN-1:0] pc_nxt, epc_nxt, cand_addr;
  logic               epc_we, mis_pc_nxt;

  pc_next #(
    .REG_LEN  (REG_LEN),
    .TRAP_VEC (TRAP_VEC),
    .STEP     (STEP),
    .IALIGN   (IALIGN)
  ) u_pc_next (
    .pc_i      (pc_q),
    .alu_out_i (alu_out),
    .pc_sel_i  (pc_sel),
    .pc_nxt_o  (pc_nxt),
    .epc_nxt_o (epc_nxt),
    .epc_we_o  (epc_we),
    .mis_pc_o  (mis_pc_nxt)
  );

  // Requests sample the registered PC, so a same-cycle update is not seen.
  assign cand_addr = (mem_sel == MEM_ALU) ? alu_out : pc_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_req_d  = mem_req_q;
    done_d     = 1'b0;
    mis_data_d = 1'b0;
    pc_d       = pc_q;
    epc_d      = epc_q;
    mis_pc_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if ((mem_sel == MEM_ALU) && data_misaligned(cand_addr[1:0], acc_size)) begin
            mis_data_d = 1'b1;
          end else begin
            addr_d    = cand_addr;
            mem_req_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem.mem_ready) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pc_upd && !mem_req_q) begin
      pc_d     = pc_nxt;
      mis_pc_d = mis_pc_nxt;
      if (epc_we) epc_d = epc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      addr_q     <= '0;
      mem_req_q  <= 1'b0;
      done_q     <= 1'b0;
      mis_pc_q   <= 1'b0;
      mis_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_q     <= addr_d;
      mem_req_q  <= mem_req_d;
      done_q     <= done_d;
      mis_pc_q   <= mis_pc_d;
      mis_data_q <= mis_data_d;
    end
  end

  assign pc          = pc_q;
  assign epc         = epc_q;
  assign mem.addr    = addr_q;
  assign mem.mem_req = mem_req_q;
  assign done        = done_q;
  assign busy        = mem_req_q;
  assign mis_pc      = mis_pc_q;
  assign mis_data    = mis_data_q;

endmodule

// File: tb/tb_mem_addr_ctrl.sv
// Directed bench for mem_addr_ctrl: reset, PC sequencing/wrap, traps,
// stall handshake, data alignment and simultaneous events.
module tb_mem_addr_ctrl;
  import mem_addr_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  pc_sel = PC_OLD;
  logic        pc_upd = 1'b0;
  logic        mem_sel = MEM_PC;
  logic [1:0]  acc_size = SZ_W;
  logic        req_valid = 1'b0;
  logic [31:0] alu_out = '0;
  logic [31:0] pc, epc;
  logic        done, busy, mis_pc, mis_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_addr_ctrl_if #(.REG_LEN(32)) mif ();

  mem_addr_ctrl #(.REG_LEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_sel    (pc_sel),
    .pc_upd    (pc_upd),
    .mem_sel   (mem_sel),
    .acc_size  (acc_size),
    .req_valid (req_valid),
    .alu_out   (alu_out),
    .pc        (pc),
    .epc       (epc),
    .done      (done),
    .busy      (busy),
    .mis_pc    (mis_pc),
    .mis_data  (mis_data),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one completion cycle then returns to idle inputs (stimulus only).
  task automatic finish_req();
    mif.mem_ready = 1'b1;
    tick();
    mif.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    mif.mem_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL rst_epc: got %h want %h", epc, 32'h0); end
    n_cmp++; if ({mif.mem_req, busy, done, mis_pc, mis_data} !== 5'b0) begin n_err++; $display("FAIL rst_flags: got %b want 00000", {mif.mem_req, busy, done, mis_pc, mis_data}); end
    n_cmp++; if (mif.addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want %h", mif.addr, 32'h0); end
    rst_n = 1'b1;
    tick();
    pc_upd = 1'b1; pc_sel = PC_P4;
    tick();
    pc_upd = 1'b0;
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL rst_pre_pc: got %h want %h", pc, 32'h4); end
    req_valid = 1'b1; mem_sel = MEM_ALU; alu_out = 32'h3000; acc_size = SZ_W;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (mif.mem_req !== 1'b1 || mif.addr !== 32'h3000) begin n_err++; $display("FAIL rst_wait_req: got req=%b addr=%h want req=1 addr=3000", mif.mem_req, mif.addr); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mif.mem_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_async: got req=%b busy=%b want 0 0", mif.mem_req, busy); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_async_pc: got %h want %h", pc, 32'h0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h0 || mif.addr !== 32'h0) begin n_err++; $display("FAIL rst_release: got pc=%h addr=%h want 0 0", pc, mif.addr); end
    $display("test_reset: async reset mid-WAIT checked");
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    pc_upd = 1'b1; pc_sel = PC_P4;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc !== exp_pc[i]) begin n_err++; $display("FAIL seq_p4_%0d: got %h want %h", i, pc, exp_pc[i]); end
      $display("seq_fetch: step %0d pc=%h", i, pc);
    end
    pc_upd = 1'b0;
  endtask

  task automatic test_wrap();
    pc_upd = 1'b1; pc_sel = PC_M4;
    tick(); tick(); tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_back0: got %h want %h", pc, 32'h0); end
    tick();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_m4: got %h want %h", pc, 32'hFFFF_FFFC); end
    pc_sel = PC_P4;
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_p4: got %h want %h", pc, 32'h0); end
    pc_sel = PC_OLD;
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL pc_old: got %h want %h", pc, 32'h0); end
    pc_sel = 3'd6;
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL pc_code6: got %h want %h", pc, 32'h0); end
    pc_upd = 1'b0;
    $display("test_wrap: modulo arithmetic checked");
  endtask

  task automatic test_busy_drop();
    req_valid = 1'b1; mem_sel = MEM_PC;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || mif.addr !== 32'h0) begin n_err++; $display("FAIL busy_req: got busy=%b addr=%h want 1 0", busy, mif.addr); end
    pc_upd = 1'b1; pc_sel = PC_P4;
    tick(); tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL busy_drop: got %h want %h", pc, 32'h0); end
    pc_upd = 1'b0;
    mif.mem_ready = 1'b1;
    tick();
    mif.mem_ready = 1'b0;
    n_cmp++; if (done !== 1'b1 || mif.mem_req !== 1'b0) begin n_err++; $display("FAIL busy_done: got done=%b req=%b want 1 0", done, mif.mem_req); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL busy_done_pulse: got %b want 0", done); end
    $display("test_busy_drop: update while busy ignored");
  endtask

  task automatic test_misaligned_jump();
    pc_upd = 1'b1; pc_sel = PC_ALU; alu_out = 32'h1002;
    tick();
    pc_upd = 1'b0;
    n_cmp++; if (pc !== 32'h100 || epc !== 32'h1002) begin n_err++; $display("FAIL misjump: got pc=%h epc=%h want 100 1002", pc, epc); end
    n_cmp++; if (mis_pc !== 1'b1) begin n_err++; $display("FAIL misjump_pulse: got %b want 1", mis_pc); end
    tick();
    n_cmp++; if (mis_pc !== 1'b0) begin n_err++; $display("FAIL misjump_pulse_end: got %b want 0", mis_pc); end
    pc_upd = 1'b1; alu_out = 32'h2000;
    tick();
    n_cmp++; if (pc !== 32'h2000 || epc !== 32'h1002 || mis_pc !== 1'b0) begin n_err++; $display("FAIL jump_ok: got pc=%h epc=%h mis=%b want 2000 1002 0", pc, epc, mis_pc); end
    pc_sel = PC_TRAP;
    tick();
    pc_upd = 1'b0;
    n_cmp++; if (pc !== 32'h100 || epc !== 32'h2000) begin n_err++; $display("FAIL trap: got pc=%h epc=%h want 100 2000", pc, epc); end
    $display("test_misaligned_jump: trap and epc capture checked");
  endtask

  task automatic test_stall();
    req_valid = 1'b1; mem_sel = MEM_ALU; alu_out = 32'h2000; acc_size = SZ_W;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_out = 32'h2004 + 32'(i * 8);
      tick();
      n_cmp++; if (mif.addr !== 32'h2000 || mif.mem_req !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL stall_%0d: got addr=%h req=%b done=%b want 2000 1 0", i, mif.addr, mif.mem_req, done); end
    end
    mif.mem_ready = 1'b1;
    tick();
    mif.mem_ready = 1'b0;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL stall_done: got done=%b busy=%b want 1 0", done, busy); end
    tick();
    $display("test_stall: addr held through 3 stall cycles");
  endtask

  task automatic test_data_mis();
    req_valid = 1'b1; mem_sel = MEM_ALU; alu_out = 32'h2001; acc_size = SZ_H;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (mis_data !== 1'b1 || mif.mem_req !== 1'b0) begin n_err++; $display("FAIL dmis_h: got mis=%b req=%b want 1 0", mis_data, mif.mem_req); end
    tick();
    n_cmp++; if (mis_data !== 1'b0) begin n_err++; $display("FAIL dmis_pulse: got %b want 0", mis_data); end
    req_valid = 1'b1; alu_out = 32'h2002; acc_size = SZ_W;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (mis_data !== 1'b1 || mif.mem_req !== 1'b0) begin n_err++; $display("FAIL dmis_w: got mis=%b req=%b want 1 0", mis_data, mif.mem_req); end
    req_valid = 1'b1; acc_size = SZ_H;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (mis_data !== 1'b0 || mif.mem_req !== 1'b1 || mif.addr !== 32'h2002) begin n_err++; $display("FAIL dok_h: got mis=%b req=%b addr=%h want 0 1 2002", mis_data, mif.mem_req, mif.addr); end
    finish_req();
    req_valid = 1'b1; alu_out = 32'h2001; acc_size = SZ_B;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (mis_data !== 1'b0 || mif.mem_req !== 1'b1 || mif.addr !== 32'h2001) begin n_err++; $display("FAIL dok_b: got mis=%b req=%b addr=%h want 0 1 2001", mis_data, mif.mem_req, mif.addr); end
    finish_req();
    $display("test_data_mis: H/W faults and B/H accepted");
  endtask

  task automatic test_simul();
    pc_upd = 1'b1; pc_sel = PC_ALU; alu_out = 32'h40;
    tick();
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL simul_setup: got %h want %h", pc, 32'h40); end
    pc_sel = PC_P4; req_valid = 1'b1; mem_sel = MEM_PC;
    tick();
    pc_upd = 1'b0; req_valid = 1'b0;
    n_cmp++; if (mif.addr !== 32'h40 || pc !== 32'h44 || mif.mem_req !== 1'b1) begin n_err++; $display("FAIL simul: got addr=%h pc=%h req=%b want 40 44 1", mif.addr, pc, mif.mem_req); end
    finish_req();
    $display("test_simul: request saw pre-update pc");
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; mem_sel = MEM_ALU; alu_out = 32'h500; acc_size = SZ_W;
    tick();
    n_cmp++; if (mif.mem_req !== 1'b1 || mif.addr !== 32'h500) begin n_err++; $display("FAIL b2b_first: got req=%b addr=%h want 1 500", mif.mem_req, mif.addr); end
    alu_out = 32'h600;
    mif.mem_ready = 1'b1;
    tick();
    mif.mem_ready = 1'b0;
    n_cmp++; if (done !== 1'b1 || mif.mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_done: got done=%b req=%b want 1 0", done, mif.mem_req); end
    tick();
    req_valid = 1'b0;
    n_cmp++; if (mif.mem_req !== 1'b1 || mif.addr !== 32'h600 || done !== 1'b0) begin n_err++; $display("FAIL b2b_second: got req=%b addr=%h done=%b want 1 600 0", mif.mem_req, mif.addr, done); end
    finish_req();
    $display("test_back_to_back: second request accepted after done");
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_seq_fetch();
    test_wrap();
    test_busy_drop();
    test_misaligned_jump();
    test_stall();
    test_data_mis();
    test_simul();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_addr_ctrl.md
# mem_addr_ctrl

Parametrised program-counter and memory-address unit with a request/ready handshake to main memory. It generalises the core's PC mux and address mux in three ways: configurable widths, a trap source with exception-PC capture, and alignment checking. It holds the address stable while memory stalls and sits between the ALU/control unit and the memory port of the core.

## Interface
Parameters:
- `REG_LEN`, 32: width of PC, ALU result and address.
- `RESET_PC`, 0: PC value after reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on trap or misaligned jump.
- `STEP`, 4: increment/decrement used by `PC_P4` / `PC_M4`.
- `IALIGN`, 2: number of PC low bits that must be zero.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_sel` in 3: PC source. Values: `PC_ALU`, `PC_P4`, `PC_M4`, `PC_OLD`, `PC_TRAP`.
- `pc_upd` in 1: apply `pc_sel` this cycle.
- `mem_sel` in 1: address source, `MEM_PC` or `MEM_ALU`.
- `acc_size` in 2: access size, `SZ_B`, `SZ_H` or `SZ_W`.
- `req_valid` in 1: core requests a memory access.
- `mem_ready` in 1: memory accepts or completes the request.
- `alu_out` in `REG_LEN`: ALU-computed target or data address.
- `pc` out `REG_LEN`: current PC.
- `epc` out `REG_LEN`: PC or faulting target captured at the last trap.
- `addr` out `REG_LEN`: memory address, valid while `mem_req`.
- `mem_req` out 1: request outstanding.
- `done` out 1: one-cycle pulse when the access completes.
- `busy` out 1: high in WAIT; PC updates are blocked.
- `mis_pc` out 1: one-cycle pulse on a misaligned jump target.
- `mis_data` out 1: one-cycle pulse on a misaligned data address.

## Operation
- The FSM has two states, IDLE and WAIT.
- **IDLE, `req_valid`=1:**
  - The candidate address is `pc` when `mem_sel`=`MEM_PC`, or `alu_out` when `MEM_ALU`.
  - If `mem_sel`=`MEM_ALU` and the address is misaligned for `acc_size`, `mis_data` pulses for 1 cycle and the FSM stays in IDLE. Misaligned means bit0≠0 for H, or bits[1:0]≠0 for W.
  - Otherwise the address is latched into `addr`, `mem_req`←1 and the FSM goes to WAIT.
- **WAIT:**
  - `addr` is held constant.
  - On `mem_ready`=1: `mem_req`←0, `done` pulses and the FSM returns to IDLE.
  - `req_valid` is ignored in WAIT.
- **PC update** happens when `pc_upd`=1 and `busy`=0:
  - `PC_ALU`: pc←`alu_out`. If `alu_out[IALIGN-1:0]`≠0: pc←`TRAP_VEC`, epc←`alu_out`, `mis_pc` pulses.
  - `PC_P4`: pc←pc+`STEP`.
  - `PC_M4`: pc←pc−`STEP`.
  - `PC_OLD`: hold.
  - `PC_TRAP`: pc←`TRAP_VEC`, epc←pc.
  - Codes 5–7: hold.
- **While busy:** a `pc_upd` is dropped. The core must hold `pc_upd` until `busy` falls.
- **Arithmetic:** modulo 2^`REG_LEN`. `PC_M4` at 0 yields 2^`REG_LEN`−`STEP`; `PC_P4` at max wraps to `STEP`−1 modulo the width.
- **Simultaneous events:**
  - A request issued in IDLE in the same cycle as a PC update samples the pre-update `pc`.
  - `done` and a new `req_valid` in the same cycle: the new request is accepted the cycle after `done`, not in the same cycle.

## Timing
- **Reset values:** pc=`RESET_PC`, epc=0, addr=0, mem_req=0, done=0, busy=0, mis_pc=0, mis_data=0, state IDLE. Reset is applied immediately on `rst_n` falling, including mid-WAIT, where the request is abandoned.
- **Request latency:** `req_valid` at edge N gives `mem_req`/`addr` valid after edge N. The minimum is 1 WAIT cycle. `done` is high in the cycle after the edge where `mem_ready` is sampled high.
- **PC latency:** the new pc is visible 1 cycle after `pc_upd` is sampled.
- All outputs are registered. `busy` equals `mem_req`.

## Structure
- A shared package/header holds:
  - `PC_*` codes (3-bit): ALU=0, P4=1, M4=2, OLD=3, TRAP=4.
  - `MEM_PC`=0, `MEM_ALU`=1.
  - `SZ_B`=0, `SZ_H`=1, `SZ_W`=2.
  - FSM state encodings.
  - `REG_LEN` default.
- One sub-module, `pc_next`: combinational next-PC computation plus the instruction-alignment check. The FSM and registers live in the top module.

## Test plan
- **Reset:** `rst_n`=0 mid-WAIT with `mem_req`=1 → mem_req=0 immediately. After release, pc=`RESET_PC`.
- **Sequential fetch and wrap:**
  - 3× `PC_P4` from 0 → pc=0xC.
  - `PC_M4` at pc=0 → 0xFFFF_FFFC.
  - A `pc_upd` while busy → pc unchanged.
- **Misaligned jump:** `PC_ALU` with `alu_out`=0x1002 → pc=0x100, epc=0x1002, `mis_pc` 1-cycle pulse.
- **Stall handshake:**
  - `req_valid`, `MEM_ALU`, `alu_out`=0x2000, `SZ_W`.
  - Hold `mem_ready`=0 for 3 cycles while `alu_out` changes → addr stays 0x2000.
  - Then `mem_ready`=1 → `done` pulse, FSM back to IDLE.
- **Data misalignment:** `SZ_H` at 0x2001 → `mis_data` pulse, no `mem_req`. `SZ_B` at 0x2001 → request issued.
- **Simultaneous request and update:** `req_valid` with `MEM_PC` plus `PC_P4` at pc=0x40 → addr=0x40, pc=0x44.
